// File: rtl/bcd_bank_selector.sv
// bcd_bank_selector
//
// Streaming front-end for the battery-bank puzzle. It consumes an ASCII
// character stream with one bank per line. For each line it finds the largest
// DIGITS-digit number that can be formed from an order-preserving subsequence
// of the line's decimal digits. That number is emitted as packed BCD, with the
// most significant digit in the top nibble, over a valid/ready handshake.
// The output width matches the operand width of the downstream BCD
// accumulation adder.
//
// Ports:
//   clk        rising-edge clock
//   resetN     asynchronous active-low reset
//   inValid    inChar is valid
//   inReady    block accepts inChar this cycle
//   inChar     ASCII character
//   inLast     final character of the whole input; also terminates the line
//   outValid   bankValue is valid
//   outReady   consumer accepts bankValue
//   bankValue  packed BCD maximum for the last completed line
//   lineCount  number of values captured since reset, wraps at 2^16
//
// Algorithm: dp[j] holds the best j-digit subsequence of the current line
// seen so far. When a digit d arrives, every length j is updated in parallel
// from the pre-update values, using the candidate {dp[j-1], d}. Plain unsigned
// compare is correct because equal-width BCD orders lexicographically.
// Entry k of the arrays below corresponds to length j = k + 1. Each entry
// keeps its digits in the low (k+1)*4 bits, and the upper bits stay zero.

module bcd_bank_selector #(
    parameter int unsigned DIGITS = 2
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                inValid,
    output logic                inReady,
    input  logic [7:0]          inChar,
    input  logic                inLast,
    output logic                outValid,
    input  logic                outReady,
    output logic [DIGITS*4-1:0] bankValue,
    output logic [15:0]         lineCount
);

    localparam int W = DIGITS * 4;

    // Line state
    logic [W-1:0]      dp_q   [DIGITS];
    logic [W-1:0]      dp_d   [DIGITS];
    logic [W-1:0]      dp_upd [DIGITS];
    logic [W-1:0]      cand   [DIGITS];
    logic [DIGITS-1:0] dpv_q;
    logic [DIGITS-1:0] dpv_d;
    logic [DIGITS-1:0] dpv_upd;
    logic [DIGITS-1:0] usable;

    // Output register
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] bank_q, bank_d;
    logic [15:0]  line_count_q, line_count_d;

    logic       accept;
    logic       is_digit;
    logic       is_term;
    logic       capture;
    logic [3:0] digit;

    // A full output that is not being drained stalls the whole input stream.
    assign inReady   = !(out_valid_q && !outReady);
    assign accept    = inValid && inReady;
    assign is_digit  = (inChar >= 8'h30) && (inChar <= 8'h39);
    assign digit     = inChar[3:0];
    assign is_term   = (inChar == 8'h0A) || inLast;

    assign outValid  = out_valid_q;
    assign bankValue = bank_q;
    assign lineCount = line_count_q;

    // Candidates: a single digit for length 1, otherwise the best shorter
    // prefix with d appended.
    always_comb begin
        cand[0]   = W'(digit);
        usable[0] = 1'b1;
        for (int k = 1; k < DIGITS; k++) begin
            cand[k]   = (dp_q[k-1] << 4) | W'(digit);
            usable[k] = dpv_q[k-1];
        end
    end

    // Post-digit view of the line state. The terminator path uses it too,
    // so a digit that carries inLast is folded in before the capture.
    always_comb begin
        for (int k = 0; k < DIGITS; k++) begin
            if (is_digit && usable[k] && (!dpv_q[k] || (cand[k] > dp_q[k]))) begin
                dp_upd[k]  = cand[k];
                dpv_upd[k] = 1'b1;
            end else begin
                dp_upd[k]  = dp_q[k];
                dpv_upd[k] = dpv_q[k];
            end
        end
    end

    assign capture = accept && is_term && dpv_upd[DIGITS-1];

    always_comb begin
        for (int k = 0; k < DIGITS; k++) begin
            dp_d[k] = dp_q[k];
        end
        dpv_d = dpv_q;
        if (accept) begin
            if (is_term) begin
                // Every line, whether captured or dropped, leaves a clean state.
                for (int k = 0; k < DIGITS; k++) begin
                    dp_d[k] = '0;
                end
                dpv_d = '0;
            end else begin
                for (int k = 0; k < DIGITS; k++) begin
                    dp_d[k] = dp_upd[k];
                end
                dpv_d = dpv_upd;
            end
        end
    end

    // Single-entry output. A capture on the same edge as a drain replaces
    // the old value, so no slot is lost.
    always_comb begin
        out_valid_d  = out_valid_q;
        bank_d       = bank_q;
        line_count_d = line_count_q;
        if (capture) begin
            out_valid_d  = 1'b1;
            bank_d       = dp_upd[DIGITS-1];
            line_count_d = line_count_q + 16'd1;
        end else if (out_valid_q && outReady) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int k = 0; k < DIGITS; k++) begin
                dp_q[k] <= '0;
            end
            dpv_q        <= '0;
            out_valid_q  <= 1'b0;
            bank_q       <= '0;
            line_count_q <= 16'd0;
        end else begin
            for (int k = 0; k < DIGITS; k++) begin
                dp_q[k] <= dp_d[k];
            end
            dpv_q        <= dpv_d;
            out_valid_q  <= out_valid_d;
            bank_q       <= bank_d;
            line_count_q <= line_count_d;
        end
    end

endmodule

// File: tb/tb_bcd_bank_selector.sv
// Testbench for bcd_bank_selector. Two instances (DIGITS=2 and DIGITS=12)
// receive the same character stream. The input is offered only when both
// instances are ready, so the two always accept identical characters.
// Expected values come from a greedy max-subsequence model and are queued
// per instance. Monitors pop and compare on each output handshake.

module tb_bcd_bank_selector;

    logic        clk;
    logic        resetN;
    logic        drv_valid;
    logic [7:0]  drv_char;
    logic        drv_last;
    logic        in_valid;

    logic        rdy2, rdy12;
    logic        outValid2, outValid12;
    logic        outReady2, outReady12;
    logic [7:0]  bank2;
    logic [47:0] bank12;
    logic [15:0] lineCount2, lineCount12;

    int n_cmp  = 0;
    int n_fail = 0;

    // 0: consumer stalled, 1: always ready, 2: random
    int ready_mode = 1;

    int           line_q[$];
    logic [63:0]  exp2[$];
    logic [63:0]  exp12[$];
    int           cnt2 = 0, cnt12 = 0;
    int           popped2 = 0, popped12 = 0;

    assign in_valid = drv_valid && rdy2 && rdy12;

    bcd_bank_selector #(.DIGITS(2)) u_dut2 (
        .clk       (clk),
        .resetN    (resetN),
        .inValid   (in_valid),
        .inReady   (rdy2),
        .inChar    (drv_char),
        .inLast    (drv_last),
        .outValid  (outValid2),
        .outReady  (outReady2),
        .bankValue (bank2),
        .lineCount (lineCount2)
    );

    bcd_bank_selector #(.DIGITS(12)) u_dut12 (
        .clk       (clk),
        .resetN    (resetN),
        .inValid   (in_valid),
        .inReady   (rdy12),
        .inChar    (drv_char),
        .inLast    (drv_last),
        .outValid  (outValid12),
        .outReady  (outReady12),
        .bankValue (bank12),
        .lineCount (lineCount12)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pick_ready();
        if (ready_mode == 0) return 1'b0;
        if (ready_mode == 1) return 1'b1;
        return ($urandom_range(0, 3) != 0);
    endfunction

    // Greedy choice: for each output position, take the largest digit that
    // still leaves enough digits after it for the remaining positions.
    function automatic logic [63:0] best_of(input int k);
        logic [63:0] r;
        int start;
        int n;
        int bi;
        r = 64'd0;
        start = 0;
        n = line_q.size();
        for (int i = 0; i < k; i++) begin
            bi = start;
            for (int p = start; p <= n - k + i; p++) begin
                if (line_q[p] > line_q[bi]) bi = p;
            end
            r = (r << 4) | 64'(line_q[bi]);
            start = bi + 1;
        end
        return r;
    endfunction

    task automatic model_accept(input logic [7:0] c, input bit last,
                                output bit cap2, output bit cap12);
        cap2 = 1'b0;
        cap12 = 1'b0;
        if (c >= 8'h30 && c <= 8'h39) line_q.push_back(int'(c) - 48);
        if (c == 8'h0A || last) begin
            if (line_q.size() >= 2) begin
                exp2.push_back(best_of(2));
                cnt2++;
                cap2 = 1'b1;
            end
            if (line_q.size() >= 12) begin
                exp12.push_back(best_of(12));
                cnt12++;
                cap12 = 1'b1;
            end
            line_q.delete();
        end
    endtask

    task automatic send(input logic [7:0] c, input bit last);
        int waited;
        bit cap2, cap12;
        waited = 0;
        @(negedge clk);
        drv_char  = c;
        drv_last  = last;
        drv_valid = 1'b1;
        #1;
        while (!(rdy2 && rdy12)) begin
            if (waited >= 1000) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_timeout: got stalled expected accepted char %h", c);
                drv_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
            waited++;
        end
        model_accept(c, last, cap2, cap12);
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        drv_last  = 1'b0;
        if (cap2)  check("latency2", 64'(outValid2), 64'd1);
        if (cap12) check("latency12", 64'(outValid12), 64'd1);
    endtask

    task automatic send_str(input string s, input bit last_on_final);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], last_on_final && (i == s.len() - 1));
        end
    endtask

    task automatic drain();
        int waited;
        ready_mode = 1;
        waited = 0;
        while ((exp2.size() != 0 || exp12.size() != 0 || outValid2 || outValid12)
               && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("drain_pending", 64'(exp2.size() + exp12.size()), 64'd0);
    endtask

    task automatic check_reset_values();
        check("rst_inReady2", 64'(rdy2), 64'd1);
        check("rst_outValid2", 64'(outValid2), 64'd0);
        check("rst_bank2", 64'(bank2), 64'd0);
        check("rst_count2", 64'(lineCount2), 64'd0);
        check("rst_inReady12", 64'(rdy12), 64'd1);
        check("rst_outValid12", 64'(outValid12), 64'd0);
        check("rst_bank12", 64'(bank12), 64'd0);
        check("rst_count12", 64'(lineCount12), 64'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        resetN = 1'b0;
        line_q.delete();
        exp2.delete();
        exp12.delete();
        cnt2 = 0;
        cnt12 = 0;
        popped2 = 0;
        popped12 = 0;
        #1;
        check_reset_values();
        @(negedge clk);
        resetN = 1'b1;
    endtask

    // Monitors: outReady changes only on the falling edge, so a handshake
    // seen here is the one the next rising edge will take.
    initial begin
        outReady2 = 1'b0;
        forever begin
            @(negedge clk);
            outReady2 = pick_ready();
            if (resetN && outValid2 && outReady2) begin
                popped2++;
                if (exp2.size() == 0) begin
                    check("unexpected2", 64'(bank2), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("value2", 64'(bank2), exp2.pop_front());
                end
                check("count2", 64'(lineCount2), 64'(popped2 & 'hFFFF));
            end
        end
    end

    initial begin
        outReady12 = 1'b0;
        forever begin
            @(negedge clk);
            outReady12 = pick_ready();
            if (resetN && outValid12 && outReady12) begin
                popped12++;
                if (exp12.size() == 0) begin
                    check("unexpected12", 64'(bank12), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("value12", 64'(bank12), exp12.pop_front());
                end
                check("count12", 64'(lineCount12), 64'(popped12 & 'hFFFF));
            end
        end
    end

    initial begin
        drv_valid = 1'b0;
        drv_char  = 8'h00;
        drv_last  = 1'b0;
        resetN    = 1'b0;
        #2;
        check_reset_values();
        repeat (2) @(negedge clk);
        resetN = 1'b1;

        // Reference banks
        ready_mode = 1;
        send_str("987654321111111\n", 1'b0);
        send_str("811111111111119\n", 1'b0);
        send_str("234234234234278\n", 1'b0);
        send_str("818181911112111\n", 1'b0);
        drain();
        check("count4_2", 64'(lineCount2), 64'd4);
        check("count4_12", 64'(lineCount12), 64'd4);

        // Short, empty and CR-bearing lines
        send_str("5\n\n12\r\n", 1'b0);
        drain();
        check("count_short2", 64'(lineCount2), 64'd5);

        // Stalled consumer
        ready_mode = 0;
        send_str("91\n", 1'b0);
        @(negedge clk);
        #2;
        check("stall_inReady", 64'(rdy2), 64'd0);
        repeat (3) @(negedge clk);
        #2;
        check("stall_hold_valid", 64'(outValid2), 64'd1);
        check("stall_hold_value", 64'(bank2), 64'h91);
        fork
            begin
                repeat (5) @(negedge clk);
                ready_mode = 1;
            end
            send_str("78\n", 1'b0);
        join
        drain();

        // inLast ends the line without a newline; the next line is clean
        send_str("47", 1'b1);
        send_str("3\n", 1'b0);
        send_str("15\n", 1'b0);
        drain();

        // Reset mid-line discards the partial line
        send_str("99", 1'b0);
        pulse_reset();
        send_str("12\n", 1'b0);
        drain();
        check("count_after_rst2", 64'(lineCount2), 64'd1);
        check("count_after_rst12", 64'(lineCount12), 64'd0);

        // Random lines with random backpressure
        ready_mode = 2;
        for (int l = 0; l < 200; l++) begin
            int len;
            bit end_last;
            len = $urandom_range(0, 20);
            end_last = (len > 0) && ($urandom_range(0, 7) == 0);
            for (int i = 0; i < len; i++) begin
                int r;
                logic [7:0] c;
                r = $urandom_range(0, 11);
                if (r < 9) c = 8'h30 + 8'($urandom_range(0, 9));
                else if (r == 9) c = 8'h0D;
                else if (r == 10) c = 8'h78;
                else c = 8'h20;
                send(c, end_last && (i == len - 1));
            end
            if (!end_last) send(8'h0A, $urandom_range(0, 15) == 0);
        end
        drain();
        check("final_count2", 64'(lineCount2), 64'(cnt2 & 'hFFFF));
        check("final_count12", 64'(lineCount12), 64'(cnt12 & 'hFFFF));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_bank_selector.md
Name: bcd_bank_selector

Overview:
- Streaming front-end that consumes an ASCII character stream, one battery bank per line.
- For each line, finds the largest K-digit number formed by an order-preserving subsequence of its decimal digits.
- Emits that number as packed BCD, most significant digit in the top nibble, over a valid/ready handshake.
- Feeds the BCD accumulation adder directly; its output width matches that adder's operand width.

Parameters:
- DIGITS, 2, K: number of digits selected per line (1..16).
- Output width is DIGITS*4.

Ports:
- clk  input  1  rising-edge clock.
- resetN  input  1  asynchronous active-low reset.
- inValid  input  1  inChar valid.
- inReady  output  1  block accepts inChar this cycle.
- inChar  input  8  ASCII character.
- inLast  input  1  marks the final character of the whole input; it also terminates the current line.
- outValid  output  1  bankValue valid.
- outReady  input  1  consumer accepts bankValue.
- bankValue  output  DIGITS*4  packed BCD maximum for the completed line.
- lineCount  output  16  number of values emitted since reset; wraps at 2^16.

Behaviour:
- Clock and reset: one clock, clk. Reset resetN is asynchronous, active-low.
- Reset values: inReady=1, outValid=0, bankValue=0, lineCount=0, all dp registers 0, all dpValid flags 0.
- Transfers: a transfer occurs when valid and ready are both high on a rising clk edge. Throughput is one character per cycle.
- State:
  - dp[j], j=1..DIGITS, each j*4 bits: best j-digit BCD subsequence of the current line so far.
  - dpValid[j]: line has seen at least j digits.
- Digit accepted ('0'..'9', value d): for every j, in parallel, computed from pre-update values:
  - cand[1] = d.
  - cand[j] = {dp[j-1], d} for j>1.
  - candidate is usable only if j==1 or dpValid[j-1].
  - If usable and (!dpValid[j] or cand[j] > dp[j]), then dp[j] <= cand[j] and dpValid[j] <= 1.
  - Comparison is plain unsigned on the packed vector; it is valid because equal-width BCD compares lexicographically.
- Line terminator: an accepted 0x0A, or any accepted character with inLast=1 (processed as a digit first if it is one).
  - If dpValid[DIGITS], capture the post-update dp[DIGITS] into bankValue, set outValid the next cycle, and increment lineCount on that capture.
  - Otherwise the line is dropped silently (empty lines, or fewer than DIGITS digits).
  - In all cases, clear dp and dpValid for the next line.
- Character filtering: 0x0D and all other non-digit characters are accepted and ignored.
- Latency: the terminator is accepted on edge N; outValid=1 with the correct bankValue after edge N.
- Output register: single entry. outValid clears on the edge where outValid&&outReady, unless a new capture occurs on that same edge (the new value replaces it and outValid stays 1).
- Backpressure: inReady = !(outValid && !outReady). A full, stalled output blocks all input, digits included.
- inLast: after its acceptance the block returns to the post-reset line state. lineCount is kept.
- Reset mid-line or with outValid=1: the partial line and the pending output are discarded.
- bankValue holds its last value while outValid=0. It is never X.

Test Plan:
- DIGITS=2; stream "987654321111111\n811111111111119\n234234234234278\n818181911112111\n", outReady=1 -> bankValue 0x98, 0x89, 0x78, 0x92, each one cycle after its '\n'; lineCount=4.
- DIGITS=12; the same four lines -> 0x987654321111, 0x811111111119, 0x434234234278, 0x888911112111.
- DIGITS=2; "5\n\n12\r\n" -> single output 0x12; CR ignored; short and empty lines produce no output; lineCount=1.
- DIGITS=2; outReady=0, send "91\n" then "78\n" -> 0x91 held, inReady drops after the second line's first char would follow; raise outReady -> 0x91 then 0x78 delivered in order, no loss.
- DIGITS=2; "47" with inLast on '7' -> 0x47 emitted without a newline; the next line starts clean.
- DIGITS=2; send "99", assert resetN=0 for one cycle mid-line, then "12\n" -> only 0x12 emitted; lineCount=1.
